memory_sync: RTL and testbench
==============================

Name: memory_sync

Overview:
- Clocked, parametrised successor to the MU0 combinational scratch memory.
- Sits between the MU0 core's memory interface (memRq/readNotWrite/addr/dataIn) and on-chip RAM; drives the board LEDs.
- Adds a four-phase request/acknowledge handshake, programmable wait states, out-of-range address detection with an error flag, and registered read data and LED outputs.

Parameters:
DATA_W, 16, data bus width in bits
ADDR_W, 16, core address bus width
DEPTH_LOG2, 5, log2 of RAM depth in words (depth = 2**DEPTH_LOG2); must be ≤ ADDR_W
WAIT_STATES, 1, extra cycles inserted before each access (0..255)
LED_W, 6, LED count; must be ≤ DATA_W
IDLE_DATA, all ones (DATA_W bits), value on dataOut when no read result is presented

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
memRq  input  1  request; held high until memAck seen, then dropped
readNotWrite  input  1  1 = read, 0 = write; sampled with request
addr  input  ADDR_W  word address; sampled with request
dataIn  input  DATA_W  write data; sampled with request
dataOut  output  DATA_W  read data, valid while memAck=1 and read
memAck  output  1  access complete
memErr  output  1  valid with memAck: address out of range
led  output  LED_W  inverted low bits of last committed write data (active-low LEDs)

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, memAck=0, memErr=0, dataOut=IDLE_DATA, led=all ones. RAM contents are not cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with memRq=1: latch readNotWrite, addr, dataIn; load counter with WAIT_STATES; go to BUSY.
  - Inputs are ignored after capture.
- BUSY:
  - Counter ≠ 0: decrement.
  - Counter = 0: perform the access, then go to DONE with memAck=1.
  - Access is committed once captured. memRq dropping during BUSY does not abort it.
- Access rules:
  - Out of range means any of latched addr[ADDR_W-1:DEPTH_LOG2] is nonzero.
  - In-range read: dataOut ← RAM[addr[DEPTH_LOG2-1:0]].
  - In-range write: RAM written; led ← ~dataIn[LED_W-1:0]; dataOut stays IDLE_DATA.
  - Out of range: memErr=1, no RAM or LED update, dataOut=IDLE_DATA.
- DONE:
  - memAck, memErr and dataOut are held while memRq=1.
  - The first edge with memRq=0 returns to IDLE and clears memAck, memErr and dataOut (to IDLE_DATA).
  - If memRq was already low on entry to DONE, memAck is a single-cycle pulse.
- Latency: request sampled at edge n → memAck high after edge n+1+WAIT_STATES.
- Throughput: a new request needs memRq low on at least one edge in DONE. It is accepted on the edge after the return to IDLE.
- Reset mid-operation:
  - Reset in BUSY before the access edge: no write occurs.
  - Reset in DONE: acknowledgement lost, the completed write is retained.
- Read-after-write: a read following a completed write to the same address returns the new data.
- Width rules:
  - Counter width is 8 bits.
  - DATA_W and LED_W are truncated from the low end as stated; no sign extension anywhere.
- Outputs are registered. No combinational path from inputs to dataOut, memAck, memErr or led.

Test Plan:
- Reset then idle: rst_n low 3 cycles → dataOut=16'hFFFF, memAck=0, memErr=0, led=6'h3F.
- Write then read, WAIT_STATES=1: write addr=3 data=16'h00A5 → memAck rises 2 edges after capture, led=6'h1A. Drop memRq → memAck clears. Read addr=3 → dataOut=16'h00A5 with memAck.
- Out of range: write addr=16'h0020 data=16'h1234 → memAck=1, memErr=1, led unchanged. Read addr=0 → prior contents, not 16'h1234.
- Wait-state sweep: WAIT_STATES=0 then 3 → memAck at edge n+1 and n+4 respectively; memRq held high keeps memAck high indefinitely.
- Early drop: memRq high one cycle only, write addr=7 data=16'h0F0F → single-cycle memAck pulse; subsequent read addr=7 returns 16'h0F0F.
- Async reset mid-access: WAIT_STATES=3, write addr=5 data=16'hBEEF, assert rst_n during BUSY → outputs at reset values immediately, no clock needed. Read addr=5 → old value, not 16'hBEEF.

Source files
------------

// File: rtl/memory_sync.sv
// Clocked MU0 scratch memory: four-phase memRq/memAck handshake, programmable wait states,
// out-of-range error flag, registered read data and active-low LED outputs.
module memory_sync #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_LOG2  = 5,
  parameter int                WAIT_STATES = 1,
  parameter int                LED_W       = 6,
  parameter logic [DATA_W-1:0] IDLE_DATA   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRq,
  input  logic              readNotWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              memAck,
  output logic              memErr,
  output logic [LED_W-1:0]  led
);

  localparam int        DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [7:0]            wait_cnt;
  logic                  rnw_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     ram [0:DEPTH-1];

  logic                  out_of_range;
  logic                  access;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_idx;

  // When the RAM spans the whole address space nothing can be out of range.
  generate
    if (DEPTH_LOG2 < ADDR_W) begin : g_range
      assign out_of_range = |addr_q[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign ram_idx = addr_q[DEPTH_LOG2-1:0];
  assign access  = (state == BUSY) && (wait_cnt == 8'd0);
  assign ram_we  = access && !rnw_q && !out_of_range;

  // RAM kept outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      memAck   <= 1'b0;
      memErr   <= 1'b0;
      dataOut  <= IDLE_DATA;
      led      <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (memRq) begin
            rnw_q    <= readNotWrite;
            addr_q   <= addr;
            data_q   <= dataIn;
            wait_cnt <= WAIT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt != 8'd0) begin
            wait_cnt <= wait_cnt - 8'd1;
          end else begin
            state  <= DONE;
            memAck <= 1'b1;
            if (out_of_range) begin
              memErr <= 1'b1;
            end else if (rnw_q) begin
              dataOut <= ram[ram_idx];
            end else begin
              led <= ~data_q[LED_W-1:0];
            end
          end
        end
        DONE: begin
          // Acknowledge holds until the core drops its request.
          if (!memRq) begin
            state   <= IDLE;
            memAck  <= 1'b0;
            memErr  <= 1'b0;
            dataOut <= IDLE_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sync.sv
// Bench for memory_sync: three instances (WAIT_STATES 1, 0, 3) checked against a
// transaction-level model every cycle, plus directed literal expectations.
module tb_memory_sync;

  localparam int N = 3;

  logic        clk;
  logic        rst_n;
  logic        memRq        [N];
  logic        readNotWrite [N];
  logic [15:0] addr         [N];
  logic [15:0] dataIn       [N];
  logic [15:0] dataOut      [N];
  logic        memAck       [N];
  logic        memErr       [N];
  logic [5:0]  led          [N];

  int checks = 0;
  int errors = 0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      memory_sync #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(5),
        .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3),
        .LED_W(6), .IDLE_DATA(16'hFFFF)
      ) dut (
        .clk(clk), .rst_n(rst_n), .memRq(memRq[g]), .readNotWrite(readNotWrite[g]),
        .addr(addr[g]), .dataIn(dataIn[g]), .dataOut(dataOut[g]),
        .memAck(memAck[g]), .memErr(memErr[g]), .led(led[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at edge E completes at edge E+1+ws,
  // then the acknowledge stays up until an edge sees memRq low.
  logic [15:0] mram   [N][32];
  bit          m_busy [N];
  bit          m_ack  [N];
  bit          m_err  [N];
  logic [15:0] m_dout [N];
  logic [5:0]  m_led  [N];
  longint      due    [N];
  bit          cap_r  [N];
  logic [15:0] cap_a  [N];
  logic [15:0] cap_d  [N];
  longint      edge_n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] <= 1'b0;
        m_ack[i]  <= 1'b0;
        m_err[i]  <= 1'b0;
        m_dout[i] <= 16'hFFFF;
        m_led[i]  <= 6'h3F;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if (!memRq[i]) begin
            m_ack[i]  <= 1'b0;
            m_err[i]  <= 1'b0;
            m_dout[i] <= 16'hFFFF;
          end
        end else if (m_busy[i]) begin
          if (edge_n == due[i]) begin
            m_busy[i] <= 1'b0;
            m_ack[i]  <= 1'b1;
            if (cap_a[i] >= 16'd32) begin
              m_err[i] <= 1'b1;
            end else if (cap_r[i]) begin
              m_dout[i] <= mram[i][cap_a[i][4:0]];
            end else begin
              mram[i][cap_a[i][4:0]] <= cap_d[i];
              m_led[i] <= ~cap_d[i][5:0];
            end
          end
        end else if (memRq[i]) begin
          m_busy[i] <= 1'b1;
          cap_r[i]  <= readNotWrite[i];
          cap_a[i]  <= addr[i];
          cap_d[i]  <= dataIn[i];
          due[i]    <= edge_n + 1 + longint'(ws_of(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("ack%0d", i),  {31'd0, memAck[i]}, {31'd0, m_ack[i]});
      chk($sformatf("err%0d", i),  {31'd0, memErr[i]}, {31'd0, m_err[i]});
      chk($sformatf("dout%0d", i), {16'd0, dataOut[i]}, {16'd0, m_dout[i]});
      chk($sformatf("led%0d", i),  {26'd0, led[i]}, {26'd0, m_led[i]});
    end
  end

  // One full handshake; inputs are scrambled right after capture to show they are ignored.
  task automatic txn(input int i, input bit rnw, input logic [15:0] a, input logic [15:0] d,
                     input bit hold, input int extra, output int lat,
                     output logic [15:0] dout, output bit err, output logic [5:0] ledv);
    bit got;
    @(negedge clk);
    memRq[i] = 1'b1; readNotWrite[i] = rnw; addr[i] = a; dataIn[i] = d;
    @(posedge clk);
    @(negedge clk);
    readNotWrite[i] = ~rnw; addr[i] = ~a; dataIn[i] = ~d;
    if (!hold) memRq[i] = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      got = memAck[i];
    end
    chk($sformatf("ack_seen%0d", i), {31'd0, got}, 32'd1);
    dout = dataOut[i]; err = memErr[i]; ledv = led[i];
    if (hold) begin
      repeat (extra) begin
        @(posedge clk); #1;
        chk($sformatf("ack_held%0d", i), {31'd0, memAck[i]}, 32'd1);
      end
      @(negedge clk);
      memRq[i] = 1'b0;
    end
    @(posedge clk); #1;
    chk($sformatf("ack_clear%0d", i), {31'd0, memAck[i]}, 32'd0);
    chk($sformatf("dout_clear%0d", i), {16'd0, dataOut[i]}, 32'h0000FFFF);
  endtask

  int          lat;
  logic [15:0] dv;
  bit          ev;
  logic [5:0]  lv;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      memRq[i] = 1'b0; readNotWrite[i] = 1'b0; addr[i] = 16'd0; dataIn[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      chk("rst_dout", {16'd0, dataOut[i]}, 32'h0000FFFF);
      chk("rst_ack",  {31'd0, memAck[i]}, 32'd0);
      chk("rst_err",  {31'd0, memErr[i]}, 32'd0);
      chk("rst_led",  {26'd0, led[i]}, 32'h3F);
    end
    rst_n = 1'b1;

    // WAIT_STATES=1 instance
    txn(0, 1'b0, 16'd0, 16'h5A5A, 1, 0, lat, dv, ev, lv);
    txn(0, 1'b0, 16'd3, 16'h00A5, 1, 0, lat, dv, ev, lv);
    chk("wr3_lat", lat, 2); chk("wr3_led", {26'd0, lv}, 32'h1A); chk("wr3_err", {31'd0, ev}, 0);
    txn(0, 1'b1, 16'd3, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("rd3_lat", lat, 2); chk("rd3_data", {16'd0, dv}, 32'h00A5);
    txn(0, 1'b0, 16'h0020, 16'h1234, 1, 0, lat, dv, ev, lv);
    chk("oor_wr_err", {31'd0, ev}, 1); chk("oor_wr_led", {26'd0, lv}, 32'h1A);
    txn(0, 1'b1, 16'd0, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("rd0_data", {16'd0, dv}, 32'h5A5A); chk("rd0_err", {31'd0, ev}, 0);
    txn(0, 1'b1, 16'h8003, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("oor_rd_err", {31'd0, ev}, 1); chk("oor_rd_data", {16'd0, dv}, 32'hFFFF);
    txn(0, 1'b0, 16'd7, 16'h0F0F, 0, 0, lat, dv, ev, lv);
    chk("pulse_lat", lat, 2); chk("pulse_led", {26'd0, lv}, 32'h30);
    txn(0, 1'b1, 16'd7, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("rd7_data", {16'd0, dv}, 32'h0F0F);
    txn(0, 1'b0, 16'd31, 16'hFFC0, 1, 0, lat, dv, ev, lv);
    chk("wr31_err", {31'd0, ev}, 0); chk("wr31_led", {26'd0, lv}, 32'h3F);
    txn(0, 1'b1, 16'd31, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("rd31_data", {16'd0, dv}, 32'hFFC0);

    // WAIT_STATES=0 instance
    txn(1, 1'b0, 16'd2, 16'h1111, 1, 0, lat, dv, ev, lv);
    chk("ws0_wr_lat", lat, 1); chk("ws0_led", {26'd0, lv}, 32'h2E);
    txn(1, 1'b1, 16'd2, 16'h0000, 1, 5, lat, dv, ev, lv);
    chk("ws0_rd_lat", lat, 1); chk("ws0_rd_data", {16'd0, dv}, 32'h1111);

    // WAIT_STATES=3 instance
    txn(2, 1'b0, 16'd5, 16'h1357, 1, 0, lat, dv, ev, lv);
    chk("ws3_wr_lat", lat, 4); chk("ws3_led", {26'd0, lv}, 32'h28);
    txn(2, 1'b1, 16'd5, 16'h0000, 1, 3, lat, dv, ev, lv);
    chk("ws3_rd_lat", lat, 4); chk("ws3_rd_data", {16'd0, dv}, 32'h1357);

    // Reset while the WAIT_STATES=3 instance is counting down
    @(negedge clk);
    memRq[2] = 1'b1; readNotWrite[2] = 1'b0; addr[2] = 16'd5; dataIn[2] = 16'hBEEF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    memRq[2] = 1'b0;
    #1;
    chk("busy_rst_ack",  {31'd0, memAck[2]}, 0);
    chk("busy_rst_led",  {26'd0, led[2]}, 32'h3F);
    chk("busy_rst_led0", {26'd0, led[0]}, 32'h3F);
    @(posedge clk); #2;
    rst_n = 1'b1;
    txn(2, 1'b1, 16'd5, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("busy_rst_keep", {16'd0, dv}, 32'h1357);

    // Reset while the WAIT_STATES=0 instance holds its acknowledge
    @(negedge clk);
    memRq[1] = 1'b1; readNotWrite[1] = 1'b0; addr[1] = 16'd9; dataIn[1] = 16'h7777;
    @(posedge clk);
    @(posedge clk); #1;
    chk("done_ack", {31'd0, memAck[1]}, 1);
    chk("done_led", {26'd0, led[1]}, 32'h08);
    #1;
    rst_n = 1'b0;
    memRq[1] = 1'b0;
    #1;
    chk("done_rst_ack", {31'd0, memAck[1]}, 0);
    chk("done_rst_led", {26'd0, led[1]}, 32'h3F);
    @(posedge clk); #2;
    rst_n = 1'b1;
    txn(1, 1'b1, 16'd9, 16'h0000, 1, 0, lat, dv, ev, lv);
    chk("done_rst_keep", {16'd0, dv}, 32'h7777);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
